alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
`default_nettype none
// ==========================================================================
// alu_muldiv : iterative RV32M multiply/divide unit, fixed 34-cycle latency.
// Define ALU_MULDIV_DIV_EN to build the divider (DIV/DIVU/REM/REMU).
// Revision  : 1.0
// ==========================================================================
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

`ifdef ALU_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_nxt;

    logic [2:0]        op;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   shreg;
    logic [2*XLEN-1:0] acc;
    logic [5:0]        cnt;

    logic              is_div;
    logic              neg1;
    logic              neg2;
    logic [XLEN-1:0]   abs1;
    logic [XLEN-1:0]   abs2;
    logic              accept;
    logic              bypass;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   fix_value;

    assign is_div  = op[2];
    assign neg1    = src1[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU) | (is_div & ~op[0]));
    assign neg2    = src2[XLEN-1] & ((op == OP_MULH) | (is_div & ~op[0]));
    assign abs1    = neg1 ? -src1 : src1;
    assign abs2    = neg2 ? -src2 : src2;
    assign accept  = (state == IDLE) & start & ~flush;
    // Without the divider, divide ops skip straight to DONE with a zero result.
    assign bypass  = ~DIV_EN & funct3[2];

    // Right-shifting shift-add: the low half of acc collects finished product bits.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (shreg[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
    assign product = (neg1 ^ neg2) ? -acc : acc;

`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN:0]   div_trial;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;

    // Restoring step: partial remainder in acc high half, dividend shifts out of shreg
    // while quotient bits shift in.
    assign div_trial = {acc[2*XLEN-1:XLEN], shreg[XLEN-1]} - {1'b0, mag_a};
    assign div_ge    = ~div_trial[XLEN];
    assign div_rem   = div_ge ? div_trial[XLEN-1:0] : {acc[2*XLEN-2:XLEN], shreg[XLEN-1]};
    assign quot      = (src2 == '0) ? {XLEN{1'b1}} : ((neg1 ^ neg2) ? -shreg : shreg);
    assign rem       = neg1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_value = is_div ? (op[1] ? rem : quot)
                              : ((op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN]);
`else
    assign fix_value = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = bypass ? DONE : PREP;
                end
            end
            PREP: state_nxt = flush ? IDLE : CALC;
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            src1   <= '0;
            src2   <= '0;
            mag_a  <= '0;
            shreg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op   <= funct3;
                        src1 <= operand1;
                        src2 <= operand2;
                        if (bypass) begin
                            result <= '0;
                        end
                    end
                end
                PREP: begin
                    mag_a <= is_div ? abs2 : abs1;
                    shreg <= is_div ? abs1 : abs2;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
`ifdef ALU_MULDIV_DIV_EN
                    if (is_div) begin
                        acc[2*XLEN-1:XLEN] <= div_rem;
                        shreg              <= {shreg[XLEN-2:0], div_ge};
                    end else begin
                        acc   <= {mul_sum, acc[XLEN-1:1]};
                        shreg <= shreg >> 1;
                    end
`else
                    acc   <= {mul_sum, acc[XLEN-1:1]};
                    shreg <= shreg >> 1;
`endif
                end
                FIX: begin
                    if (!flush) begin
                        result <= fix_value;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// tb_alu_muldiv : random and directed checks of alu_muldiv against an arithmetic model.
module tb_alu_muldiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] operand1 = 32'd0;
    logic [31:0] operand2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = 32'd0;

`ifdef ALU_MULDIV_DIV_EN
    localparam bit HAS_DIV = 1'b1;
`else
    localparam bit HAS_DIV = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        pu = {32'd0, a} * {32'd0, b};
        p  = 0;
        if (f[2] && !HAS_DIV) return 32'd0;
        case (f)
            3'd0: p = longint'(pu);
            3'd1: p = (sa * sb) >>> 32;
            3'd2: p = (sa * ub) >>> 32;
            3'd3: p = longint'(pu >> 32);
            3'd4: p = (b == 0) ? -1 : sa / sb;
            3'd5: p = (b == 0) ? -1 : longint'(a / b);
            3'd6: p = (b == 0) ? sa : sa % sb;
            default: p = (b == 0) ? longint'({32'd0, a}) : longint'(a % b);
        endcase
        return p[31:0];
    endfunction

    // Issues one op, waits for done, checks latency, result and the single-cycle pulse.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit release_rst);
        int          n;
        int          lat;
        logic        busy_ok;
        logic [31:0] exp;
        exp = model(f, a, b);
        lat = (f[2] && !HAS_DIV) ? 0 : 34;
        @(negedge clk);
        if (release_rst) rst_n = 1'b1;
        start    = 1'b1;
        funct3   = f;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        funct3   = 3'($urandom);
        operand1 = $urandom;
        operand2 = $urandom;
        n        = 0;
        busy_ok  = busy;
        while (!done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            busy_ok = busy_ok & busy;
        end
        check($sformatf("latency f%0d", f), 32'(n), 32'(lat));
        check($sformatf("busy_held f%0d", f), 32'(busy_ok), 32'd1);
        check($sformatf("result f%0d %h %h", f, a, b), result, exp);
        @(posedge clk);
        #1;
        check("done_pulse_end", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        last_result = exp;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          ndone;
        logic [31:0] cap;
        logic [31:0] exp;

        #2 rst_n = 1'b0;
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        repeat (3) @(posedge clk);

        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        run_op(3'd5, 32'd100, 32'd0, 1'b0);
        run_op(3'd7, 32'd100, 32'd0, 1'b0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(3'd4, 32'd10, 32'd2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0);
        end

        // Flush in CALC cycle 10: abort, no done, result retained.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) ndone++;
        end
        check("flush_no_done", 32'(ndone), 32'd0);
        check("flush_result_kept", result, last_result);

        // Flush wins over start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0;
        @(posedge clk);
        #1 start = 1'b0; flush = 1'b0;
        check("flush_over_start", 32'(busy), 32'd0);

        // A second start while busy is ignored.
        operand1 = $urandom; operand2 = $urandom;
        exp = model(3'd1, operand1, operand2);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1; funct3 = 3'd0; operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        cap   = 32'd0;
        repeat (60) begin
            @(posedge clk);
            #1 if (done) begin ndone++; cap = result; end
        end
        check("ignored_start_dones", 32'(ndone), 32'd1);
        check("ignored_start_result", cap, exp);

        // Asynchronous reset mid-CALC, then accept at the first edge after release.
        @(negedge clk);
        start = 1'b1; funct3 = 3'd3; operand1 = $urandom; operand2 = $urandom;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_result", result, 32'd0);
        run_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
